// File: rtl/vocab_match_ctrl.sv
// Scans a zero-terminated vocabulary held in a registered SRAM for one query word
// and reports hit, entry number and entry start address.
module vocab_match_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  output logic                              ready,
  output logic                              done,
  output logic                              hit,
  output logic [ADDR_WIDTH-1:0]             match_index,
  output logic [ADDR_WIDTH-1:0]             match_addr,
  output logic                              sram_cs,
  output logic [ADDR_WIDTH-1:0]             sram_addr,
  input  logic [DATA_WIDTH-1:0]             sram_dout
);

  localparam int KW = $clog2(WORD_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN, DONE} state_t;

  state_t                            state_q, state_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic [KW-1:0]                     charIdx_q, charIdx_d;
  logic                              mismatch_q, mismatch_d;
  logic [ADDR_WIDTH-1:0]             entryIdx_q, entryIdx_d;
  logic [ADDR_WIDTH-1:0]             entryStart_q, entryStart_d;
  logic                              hit_q, hit_d;
  logic [ADDR_WIDTH-1:0]             matchIndex_q, matchIndex_d;
  logic [ADDR_WIDTH-1:0]             matchAddr_q, matchAddr_d;
  logic                              sramCs_q, sramCs_d;
  logic [ADDR_WIDTH-1:0]             sramAddr_q, sramAddr_d;

  logic [ADDR_WIDTH-1:0] addrEval;
  logic                  lastAddr;
  logic [DATA_WIDTH-1:0] expChar;
  logic                  finishHit;
  logic                  finishMiss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      charIdx_q    <= '0;
      mismatch_q   <= 1'b0;
      entryIdx_q   <= '0;
      entryStart_q <= '0;
      hit_q        <= 1'b0;
      matchIndex_q <= '0;
      matchAddr_q  <= '0;
      sramCs_q     <= 1'b0;
      sramAddr_q   <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      charIdx_q    <= charIdx_d;
      mismatch_q   <= mismatch_d;
      entryIdx_q   <= entryIdx_d;
      entryStart_q <= entryStart_d;
      hit_q        <= hit_d;
      matchIndex_q <= matchIndex_d;
      matchAddr_q  <= matchAddr_d;
      sramCs_q     <= sramCs_d;
      sramAddr_q   <= sramAddr_d;
    end
  end

  // The byte on sram_dout belongs to the address issued one cycle earlier.
  assign addrEval = sramAddr_q - ADDR_WIDTH'(1);
  assign lastAddr = (addrEval == {ADDR_WIDTH{1'b1}});

  always_comb begin
    expChar = '0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (charIdx_q == KW'(i)) expChar = word_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    charIdx_d    = charIdx_q;
    mismatch_d   = mismatch_q;
    entryIdx_d   = entryIdx_q;
    entryStart_d = entryStart_q;
    hit_d        = hit_q;
    matchIndex_d = matchIndex_q;
    matchAddr_d  = matchAddr_q;
    sramCs_d     = sramCs_q;
    sramAddr_d   = sramAddr_q;
    finishHit    = 1'b0;
    finishMiss   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d       = word;
          hit_d        = 1'b0;
          charIdx_d    = '0;
          mismatch_d   = 1'b0;
          entryIdx_d   = '0;
          entryStart_d = '0;
          if (word[DATA_WIDTH-1:0] == '0) begin
            matchIndex_d = '0;
            matchAddr_d  = '0;
            state_d      = DONE;
          end else begin
            sramAddr_d = '0;
            sramCs_d   = 1'b1;
            state_d    = PRIME;
          end
        end
      end
      PRIME: begin
        sramAddr_d = ADDR_WIDTH'(1);
        state_d    = SCAN;
      end
      SCAN: begin
        sramAddr_d = sramAddr_q + ADDR_WIDTH'(1);
        if (sram_dout != '0) begin
          if (sram_dout != expChar) mismatch_d = 1'b1;
          if (charIdx_q != KW'(WORD_LENGTH)) charIdx_d = charIdx_q + KW'(1);
          if (lastAddr) finishMiss = 1'b1;
        end else if (addrEval == entryStart_q) begin
          finishMiss = 1'b1;
        end else if (!mismatch_q && expChar == '0) begin
          finishHit = 1'b1;
        end else begin
          entryIdx_d   = entryIdx_q + ADDR_WIDTH'(1);
          entryStart_d = addrEval + ADDR_WIDTH'(1);
          charIdx_d    = '0;
          mismatch_d   = 1'b0;
          if (lastAddr) finishMiss = 1'b1;
        end
        if (finishHit || finishMiss) begin
          sramCs_d     = 1'b0;
          state_d      = DONE;
          hit_d        = finishHit;
          matchIndex_d = finishHit ? entryIdx_q : '0;
          matchAddr_d  = finishHit ? entryStart_q : '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign hit         = hit_q;
  assign match_index = matchIndex_q;
  assign match_addr  = matchAddr_q;
  assign sram_cs     = sramCs_q;
  assign sram_addr   = sramAddr_q;

endmodule

// File: tb/tb_vocab_match_ctrl.sv
// Scoreboard bench for vocab_match_ctrl: a string-level reference scan predicts each
// result and its latency, and a monitor compares when done pulses.
module tb_vocab_match_ctrl;

  localparam int AW    = 4;
  localparam int WL    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic hit;
    int   idx;
    int   addr;
    int   lat;
    int   startCyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WL*DW-1:0]  word;
  logic              ready;
  logic              done;
  logic              hit;
  logic [AW-1:0]     matchIndex;
  logic [AW-1:0]     matchAddr;
  logic              sramCs;
  logic [AW-1:0]     sramAddr;
  logic [DW-1:0]     sramDout = '0;

  logic [DW-1:0] mem [DEPTH];
  exp_t          sb[$];
  int            cyc = 0;
  int            checkCount = 0;
  int            errorCount = 0;
  logic          csSeen = 1'b0;

  vocab_match_ctrl #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .word(word), .ready(ready), .done(done),
    .hit(hit), .match_index(matchIndex), .match_addr(matchAddr),
    .sram_cs(sramCs), .sram_addr(sramAddr), .sram_dout(sramDout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sramCs) sramDout <= mem[sramAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sramCs) csSeen = 1'b1;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("hit", 32'(hit), 32'(e.hit));
        checkOutput("match_index", 32'(matchIndex), e.idx);
        checkOutput("match_addr", 32'(matchAddr), e.addr);
        checkOutput("latency", cyc - e.startCyc, e.lat);
        checkOutput("cs_at_done", 32'(sramCs), 32'd0);
      end
    end
  end

  // '.' stands for the 0x00 terminator so vocabularies read naturally.
  task automatic loadVocab(input string s);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < s.len() && i < DEPTH; i++) mem[i] = (s[i] == 8'h2E) ? 8'h00 : s[i];
  endtask

  function automatic logic [WL*DW-1:0] packWord(input string s);
    logic [WL*DW-1:0] w = '0;
    for (int i = 0; i < s.len() && i < WL; i++) w[i*DW +: DW] = s[i];
    return w;
  endfunction

  function automatic exp_t refScan(input logic [WL*DW-1:0] w);
    exp_t e;
    int   pos, idx, len;
    bit   ok;
    e = '{hit: 1'b0, idx: 0, addr: 0, lat: 0, startCyc: 0};
    if (w[DW-1:0] == '0) begin
      e.lat = 1;
      return e;
    end
    pos = 0;
    idx = 0;
    for (int guard = 0; guard <= DEPTH; guard++) begin
      if (mem[pos] == '0) begin
        e.lat = 3 + pos;
        return e;
      end
      len = 0;
      while (pos + len < DEPTH && mem[pos+len] != '0) len++;
      if (pos + len == DEPTH) begin
        e.lat = 3 + DEPTH - 1;
        return e;
      end
      ok = (len <= WL);
      for (int i = 0; i < len; i++) begin
        if (ok && i < WL && mem[pos+i] != w[i*DW +: DW]) ok = 1'b0;
      end
      if (ok && len < WL && w[len*DW +: DW] != '0) ok = 1'b0;
      if (ok) begin
        e.hit  = 1'b1;
        e.idx  = idx;
        e.addr = pos;
        e.lat  = 3 + pos + len;
        return e;
      end
      if (pos + len == DEPTH - 1) begin
        e.lat = 3 + DEPTH - 1;
        return e;
      end
      pos = pos + len + 1;
      idx++;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [WL*DW-1:0] w);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
    e          = refScan(w);
    e.startCyc = cyc;
    sb.push_back(e);
    start = 1'b1;
    word  = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic runWord(input string s);
    applyStimulus(packWord(s));
    waitDone();
  endtask

  initial begin
    logic [WL*DW-1:0] w;
    int               len;
    rst   = 1'b1;
    start = 1'b0;
    word  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hit", 32'(hit), 32'd0);
    checkOutput("rst_cs", 32'(sramCs), 32'd0);
    checkOutput("rst_addr", 32'(sramAddr), 32'd0);
    checkOutput("rst_index", 32'(matchIndex), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    loadVocab("cat.dog..");
    runWord("dog");
    runWord("cat");
    runWord("ca");
    runWord("og");
    loadVocab("do..");
    runWord("dog");
    loadVocab("abcdefghijklmnop");
    runWord("abc");

    loadVocab("cat.dog..");
    csSeen = 1'b0;
    runWord("");
    checkOutput("cs_empty_word", 32'(csSeen), 32'd0);

    // A start during a scan must neither restart it nor replace the latched word.
    applyStimulus(packWord("dog"));
    repeat (2) @(negedge clk);
    start = 1'b1;
    word  = packWord("cat");
    @(negedge clk);
    start = 1'b0;
    waitDone();

    // Reset five cycles into a scan drops it with no done pulse.
    applyStimulus(packWord("dog"));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_cs", 32'(sramCs), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_addr", 32'(sramAddr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    runWord("dog");

    loadVocab("abc.ab.ba.aaa.b.");
    runWord("b");
    runWord("bb");
    runWord("aaa");
    runWord("ab");

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 4))
          0:       mem[i] = 8'h00;
          1, 2:    mem[i] = 8'h61;
          default: mem[i] = 8'h62;
        endcase
      end
      len = $urandom_range(0, WL);
      w   = '0;
      for (int i = 0; i < len; i++) w[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 8'h61 : 8'h62;
      applyStimulus(w);
      waitDone();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
